mole_round_ctrl: RTL and testbench
==================================

Name: mole_round_ctrl

Overview:
- Round sequencer for the whack-a-mole game; it produces the timing events that the reaction-timer display consumes.
- Waits a pseudo-random delay, raises one mole LED and pulses start_evt, then watches the player buttons.
- Pulses stop_evt on a correct hit, on timeout, or on abort, and keeps score and miss counts.

Parameters:
- CLKS_PER_MS, 50000, clock cycles per 1 ms tick (50 MHz).
- NUM_MOLES, 4, number of moles/buttons; legal values 2, 4, 8 only (power of two).
- MIN_DELAY_MS, 500, minimum pre-mole delay in ms.
- TIMEOUT_MS, 99, maximum time the mole stays up, in ms.
- HOLD_MS, 1000, result hold time before the next round, in ms.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  level; game running.
- hit_btn  in  NUM_MOLES  player buttons; active-high level, already synchronised and debounced.
- mole_led  out  NUM_MOLES  one-hot mole indicator; all zero when no mole is up.
- start_evt  out  1  single-cycle pulse when the mole appears.
- stop_evt  out  1  single-cycle pulse when the round ends.
- score  out  8  correct-hit count; saturates at 255.
- miss_cnt  out  8  timeout/miss count; saturates at 255.
- round_active  out  1  high while in MOLE_UP.

Behaviour:
- Reset: state IDLE; all outputs 0; LFSR = 16'hACE1; tick and ms counters 0; button history 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock including IDLE, never reset except by rst.
- Tick generator: counts 0..CLKS_PER_MS-1 and emits a tick on the terminal count. Cleared on every state entry.
- ms_cnt: counts ticks; cleared on every state entry.
- Button edge: edge[i] = hit_btn[i] & ~hit_prev[i]. hit_prev is registered every cycle in all states, so a button already held when the mole rises does not count as a hit.
- IDLE: enable=1 -> WAIT_DELAY.
- WAIT_DELAY entry:
  - latch delay_ms = MIN_DELAY_MS + lfsr[9:0] (11-bit-plus sum, no wrap);
  - latch mole_idx = lfsr[15 -: log2(NUM_MOLES)].
- WAIT_DELAY exit: when ms_cnt == delay_ms -> MOLE_UP.
- MOLE_UP:
  - first cycle: start_evt=1, mole_led = one-hot(mole_idx), round_active=1;
  - mole_led and round_active stay high for the whole state.
- MOLE_UP exits, checked in priority order each clock edge:
  1. edge[mole_idx] -> score+1 (saturating), -> RESULT.
  2. ms_cnt == TIMEOUT_MS -> miss_cnt+1 (saturating), -> RESULT.
  3. Any other edge: ignored (see optional feature).
- MOLE_UP exit outputs: in the cycle after the deciding edge, stop_evt=1 and mole_led=0.
- Simultaneous events in MOLE_UP:
  - correct and wrong buttons together -> correct hit wins;
  - hit on the same cycle as timeout -> hit wins.
- RESULT: when ms_cnt == HOLD_MS -> WAIT_DELAY if enable, else IDLE.
- enable low in any non-IDLE state: next cycle -> IDLE, mole_led=0.
  - If aborted from MOLE_UP, stop_evt pulses once; score and miss_cnt are unchanged.
  - enable low takes priority over all other MOLE_UP events.
- start_evt and stop_evt:
  - never high in the same cycle;
  - each exactly 1 cycle wide;
  - exactly one stop_evt per start_evt.
- score and miss_cnt are cleared only by rst.

Optional Feature:
- Macro: WRONG_HIT_PENALTY_EN.
- Defined: in MOLE_UP, an edge on any button other than mole_idx, with no correct edge in the same cycle:
  - miss_cnt+1 (saturating);
  - stop_evt pulse;
  - -> RESULT.
  - Priority: correct hit > wrong hit > timeout.
- Undefined: wrong-button edges are ignored and the mole stays up.

Test Plan:
- Directed scenarios below use CLKS_PER_MS=10, MIN_DELAY_MS=5, TIMEOUT_MS=20, HOLD_MS=3.
- Reset -> all outputs 0. Assert enable -> start_evt exactly once, between 5 and 1028 ms later. mole_led one-hot and equal to the bench LFSR model.
- Mole up, press the correct button 7 ms after start_evt -> stop_evt 1 cycle after the edge, mole_led=0, score=1, miss_cnt=0, next round after 3 ms.
- No press -> stop_evt at 20 ms after start_evt, miss_cnt=1, score unchanged.
- Correct button held down before start_evt and kept held -> no hit, timeout at 20 ms. Then release and re-press in the next round -> hit counted.
- Deassert enable mid MOLE_UP -> one stop_evt, IDLE, counters unchanged. Pulse rst mid WAIT_DELAY -> all outputs 0 the next cycle.
- Wrong button in MOLE_UP, and wrong plus correct together:
  - macro off: wrong button ignored;
  - macro on: miss_cnt+1 and round ends;
  - both together: counted as a hit in either build.
- 300 forced hits -> score saturates at 255.

Source files
------------

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: random pre-mole delay, mole display, hit/timeout/abort scoring.
// Optional macro WRONG_HIT_PENALTY_EN: a wrong-button edge ends the round as a miss.
module mole_round_ctrl #(
  parameter int unsigned CLKS_PER_MS  = 50000,
  parameter int unsigned NUM_MOLES    = 4,
  parameter int unsigned MIN_DELAY_MS = 500,
  parameter int unsigned TIMEOUT_MS   = 99,
  parameter int unsigned HOLD_MS      = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_MOLES-1:0] hit_btn,
  output logic [NUM_MOLES-1:0] mole_led,
  output logic                 start_evt,
  output logic                 stop_evt,
  output logic [7:0]           score,
  output logic [7:0]           miss_cnt,
  output logic                 round_active
);

  localparam int unsigned IDX_W     = $clog2(NUM_MOLES);
  localparam int unsigned TICK_W    = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int unsigned MAX_DELAY = MIN_DELAY_MS + 1023;
  localparam int unsigned MAX_MS_A  = (MAX_DELAY > TIMEOUT_MS) ? MAX_DELAY : TIMEOUT_MS;
  localparam int unsigned MAX_MS    = (MAX_MS_A > HOLD_MS) ? MAX_MS_A : HOLD_MS;
  localparam int unsigned MS_W      = $clog2(MAX_MS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_MOLE   = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  logic [1:0]           state, state_nxt;
  logic [TICK_W-1:0]    tick_cnt;
  logic [MS_W-1:0]      ms_cnt;
  logic [MS_W-1:0]      delay_ms;
  logic [IDX_W-1:0]     mole_idx;
  logic [15:0]          lfsr;
  logic [NUM_MOLES-1:0] hit_prev;
  logic [NUM_MOLES-1:0] btn_edge;
  logic [NUM_MOLES-1:0] mole_oh;
  logic                 tick;
  logic                 hit_ok;
  logic                 entry;

  logic [NUM_MOLES-1:0] mole_led_nxt;
  logic                 start_nxt;
  logic                 stop_nxt;
  logic                 active_nxt;
  logic [7:0]           score_nxt;
  logic [7:0]           miss_nxt;

  assign tick     = (tick_cnt == TICK_W'(CLKS_PER_MS - 1));
  assign btn_edge = hit_btn & ~hit_prev;
  assign mole_oh  = NUM_MOLES'(1) << mole_idx;
  assign hit_ok   = btn_edge[mole_idx];
  assign entry    = (state_nxt != state);

`ifdef WRONG_HIT_PENALTY_EN
  logic hit_wrong;
  assign hit_wrong = |(btn_edge & ~mole_oh);
`endif

  // Next state, counter updates and registered-output next values
  always_comb begin
    state_nxt    = state;
    score_nxt    = score;
    miss_nxt     = miss_cnt;
    start_nxt    = 1'b0;
    stop_nxt     = 1'b0;
    active_nxt   = 1'b0;
    mole_led_nxt = '0;
    case (state)
      S_IDLE: begin
        if (enable) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!enable) state_nxt = S_IDLE;
        else if (ms_cnt == delay_ms) state_nxt = S_MOLE;
      end
      S_MOLE: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (hit_ok) begin
          state_nxt = S_RESULT;
          score_nxt = (score == 8'hFF) ? score : score + 8'd1;
`ifdef WRONG_HIT_PENALTY_EN
        end else if (hit_wrong) begin
          state_nxt = S_RESULT;
          miss_nxt  = (miss_cnt == 8'hFF) ? miss_cnt : miss_cnt + 8'd1;
`endif
        end else if (ms_cnt == MS_W'(TIMEOUT_MS)) begin
          state_nxt = S_RESULT;
          miss_nxt  = (miss_cnt == 8'hFF) ? miss_cnt : miss_cnt + 8'd1;
        end
      end
      S_RESULT: begin
        if (!enable) state_nxt = S_IDLE;
        else if (ms_cnt == MS_W'(HOLD_MS)) state_nxt = S_WAIT;
      end
      default: state_nxt = S_IDLE;
    endcase
    start_nxt    = (state_nxt == S_MOLE) && (state != S_MOLE);
    stop_nxt     = (state == S_MOLE) && (state_nxt != S_MOLE);
    active_nxt   = (state_nxt == S_MOLE);
    mole_led_nxt = active_nxt ? mole_oh : '0;
  end

  // State register plus timing, LFSR and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      tick_cnt     <= '0;
      ms_cnt       <= '0;
      delay_ms     <= '0;
      mole_idx     <= '0;
      lfsr         <= 16'hACE1;
      hit_prev     <= '0;
      mole_led     <= '0;
      start_evt    <= 1'b0;
      stop_evt     <= 1'b0;
      score        <= 8'd0;
      miss_cnt     <= 8'd0;
      round_active <= 1'b0;
    end else begin
      state    <= state_nxt;
      lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      hit_prev <= hit_btn;
      if (entry) begin
        tick_cnt <= '0;
        ms_cnt   <= '0;
      end else if (tick) begin
        tick_cnt <= '0;
        ms_cnt   <= ms_cnt + MS_W'(1);
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
      // Round parameters are drawn from the LFSR value present at the entry edge
      if ((state_nxt == S_WAIT) && (state != S_WAIT)) begin
        delay_ms <= MS_W'(MIN_DELAY_MS) + MS_W'(lfsr[9:0]);
        mole_idx <= lfsr[15 -: IDX_W];
      end
      mole_led     <= mole_led_nxt;
      start_evt    <= start_nxt;
      stop_evt     <= stop_nxt;
      score        <= score_nxt;
      miss_cnt     <= miss_nxt;
      round_active <= active_nxt;
    end
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Scoreboard bench for mole_round_ctrl: expected start/stop events are queued by the stimulus
// and checked by monitors; a second fast-clocked instance exercises score saturation.
`timescale 1ns/1ps
module tb_mole_round_ctrl;

  logic       clk = 1'b0;
  logic       rst, enable;
  logic [3:0] hit_btn, mole_led;
  logic       start_evt, stop_evt, round_active;
  logic [7:0] score, miss_cnt;

  logic       s_enable;
  logic [3:0] s_hit, s_mole_led;
  logic       s_start_evt, s_stop_evt, s_round_active;
  logic [7:0] s_score, s_miss_cnt;

  always #5 clk = ~clk;

  mole_round_ctrl #(.CLKS_PER_MS(10), .NUM_MOLES(4), .MIN_DELAY_MS(5), .TIMEOUT_MS(20), .HOLD_MS(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .hit_btn(hit_btn), .mole_led(mole_led),
    .start_evt(start_evt), .stop_evt(stop_evt), .score(score), .miss_cnt(miss_cnt),
    .round_active(round_active));

  mole_round_ctrl #(.CLKS_PER_MS(1), .NUM_MOLES(4), .MIN_DELAY_MS(1), .TIMEOUT_MS(20), .HOLD_MS(3)) dut_sat (
    .clk(clk), .rst(rst), .enable(s_enable), .hit_btn(s_hit), .mole_led(s_mole_led),
    .start_evt(s_start_evt), .stop_evt(s_stop_evt), .score(s_score), .miss_cnt(s_miss_cnt),
    .round_active(s_round_active));

  typedef struct packed {
    logic        is_stop;
    logic [31:0] at;
    logic [3:0]  led;
    logic [7:0]  sc;
    logic [7:0]  mi;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] sat_q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         e_score, e_miss;
  int         r_start, r_idx;
  logic [15:0] mdl_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = lfsr_step(r);
    return r;
  endfunction

  // Reference LFSR and cycle index, both aligned with the DUT clock
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) mdl_lfsr <= 16'hACE1;
    else     mdl_lfsr <= lfsr_step(mdl_lfsr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input logic stp, input int at, input logic [3:0] led);
    ev_t e;
    e.is_stop = stp;
    e.at      = 32'(at);
    e.led     = led;
    e.sc      = 8'(e_score);
    e.mi      = 8'(e_miss);
    exp_q.push_back(e);
  endtask

  // v is the LFSR value in the cycle before WAIT_DELAY entry; mole rises after ms_cnt reaches the delay
  task automatic sched_start(input int entry, input logic [15:0] v);
    r_start = entry + 10 * (5 + int'(v[9:0])) + 1;
    r_idx   = int'(v[15:14]);
    push_ev(1'b0, r_start, 4'b0001 << r_idx);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Raise enable from IDLE on a cycle with a short LFSR delay to keep runtime low
  task automatic start_fast();
    int n;
    n = 0;
    while (mdl_lfsr[9:0] >= 10'd64 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b1;
    sched_start(cyc + 1, mdl_lfsr);
  endtask

  task automatic end_to_idle(input int s);
    wait_cyc(s);
    enable  = 1'b0;
    hit_btn = '0;
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mole_led"}, 32'(mole_led), 0);
    chk({tag, "_start_evt"}, 32'(start_evt), 0);
    chk({tag, "_stop_evt"}, 32'(stop_evt), 0);
    chk({tag, "_score"}, 32'(score), 0);
    chk({tag, "_miss_cnt"}, 32'(miss_cnt), 0);
    chk({tag, "_round_active"}, 32'(round_active), 0);
  endtask

  // Main-instance monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (start_evt && stop_evt) chk("start_stop_overlap", 32'(1), 0);
      if (start_evt || stop_evt) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_evt: start=%0d stop=%0d at cycle %0d, expected no event",
                   start_evt, stop_evt, cyc);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("evt_kind_is_stop", 32'(stop_evt), 32'(e.is_stop));
          chk("evt_cycle", 32'(cyc), e.at);
          chk("evt_mole_led", 32'(mole_led), 32'(e.led));
          chk("evt_round_active", 32'(round_active), 32'(!e.is_stop));
          chk("evt_score", 32'(score), 32'(e.sc));
          chk("evt_miss_cnt", 32'(miss_cnt), 32'(e.mi));
        end
      end
    end
  end

  // Saturation-instance monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (s_start_evt && s_stop_evt) chk("sat_start_stop_overlap", 32'(1), 0);
      if (s_stop_evt) begin
        if (sat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sat_unexpected_stop: at cycle %0d, expected none", cyc);
        end else begin
          logic [7:0] want;
          want = sat_q.pop_front();
          chk("sat_score", 32'(s_score), 32'(want));
        end
      end
    end
  end

  task automatic run_saturation();
    int k, st;
    logic [15:0] v;
    for (int n = 1; n <= 300; n++) begin
      k = 0;
      while (mdl_lfsr[9:0] >= 10'd32 && k < 5000) begin
        @(negedge clk);
        k++;
      end
      v = mdl_lfsr;
      s_enable = 1'b1;
      st = cyc + 1 + (1 + int'(v[9:0])) + 1;
      wait_cyc(st);
      s_hit[v[15:14]] = 1'b1;
      sat_q.push_back((n > 255) ? 8'd255 : 8'(n));
      @(negedge clk);
      s_hit    = '0;
      s_enable = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int t, idx, wr;
    rst = 1'b1; enable = 1'b0; hit_btn = '0; s_enable = 1'b0; s_hit = '0;
    e_score = 0; e_miss = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Correct hit 7 ms after the mole rises; next round follows the 3 ms hold
    start_fast();
    idx = r_idx;
    t = r_start + 70;
    wait_cyc(t);
    hit_btn[idx] = 1'b1;
    e_score++;
    push_ev(1'b1, t + 1, 4'b0000);
    sched_start(t + 1 + 31, lfsr_adv(mdl_lfsr, (t + 1 + 30) - cyc));
    wait_cyc(t + 3);
    hit_btn = '0;

    // No press: timeout
    e_miss++;
    push_ev(1'b1, r_start + 201, 4'b0000);
    end_to_idle(r_start + 201);

    // Button held across the mole rise is not a hit
    start_fast();
    wait_cyc(r_start - 5);
    hit_btn[r_idx] = 1'b1;
    e_miss++;
    push_ev(1'b1, r_start + 201, 4'b0000);
    end_to_idle(r_start + 201);

    // Released and re-pressed in a fresh round
    start_fast();
    t = r_start + 30;
    wait_cyc(t);
    hit_btn[r_idx] = 1'b1;
    e_score++;
    push_ev(1'b1, t + 1, 4'b0000);
    end_to_idle(t + 1);

    // Wrong button alone, then wrong plus correct together
    start_fast();
    idx = r_idx;
    wr = (idx + 1) % 4;
    t = r_start + 40;
    wait_cyc(t);
    hit_btn[wr] = 1'b1;
`ifdef WRONG_HIT_PENALTY_EN
    e_miss++;
    push_ev(1'b1, t + 1, 4'b0000);
    end_to_idle(t + 1);
    start_fast();
    idx = r_idx;
    wr = (idx + 1) % 4;
`else
    wait_cyc(t + 5);
    hit_btn = '0;
`endif
    t = r_start + 50;
    wait_cyc(t);
    hit_btn[idx] = 1'b1;
    hit_btn[wr]  = 1'b1;
    e_score++;
    push_ev(1'b1, t + 1, 4'b0000);
    end_to_idle(t + 1);

    // Abort mid MOLE_UP: one stop, counters held
    start_fast();
    t = r_start + 50;
    wait_cyc(t);
    enable = 1'b0;
    push_ev(1'b1, t + 1, 4'b0000);
    wait_cyc(t + 2);
    chk("abort_mole_led", 32'(mole_led), 0);
    chk("abort_round_active", 32'(round_active), 0);
    chk("abort_score", 32'(score), 32'(e_score));
    chk("abort_miss_cnt", 32'(miss_cnt), 32'(e_miss));

    // Reset during WAIT_DELAY
    enable = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    enable = 1'b0;
    e_score = 0;
    e_miss = 0;
    @(negedge clk);

    // LFSR reseeded: timeout round after reset
    start_fast();
    e_miss++;
    push_ev(1'b1, r_start + 201, 4'b0000);
    end_to_idle(r_start + 201);

    run_saturation();

    repeat (5) @(negedge clk);
    chk("pending_events", 32'(exp_q.size()), 0);
    chk("sat_pending", 32'(sat_q.size()), 0);
    chk("sat_final_score", 32'(s_score), 255);
    chk("sat_final_miss", 32'(s_miss_cnt), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
